// File: rtl/trace_pkg.sv
// Shared trace record layout, word type codes and serializer encodings.
package trace_pkg;

  localparam int DATA_W = 16;
  localparam int IDX_W  = 3;
  localparam int TYPE_W = 3;

  typedef enum logic [TYPE_W-1:0] {
    TYPE_REG   = 3'b001,
    TYPE_LOAD  = 3'b010,
    TYPE_STORE = 3'b011,
    TYPE_HALT  = 3'b100
  } traceType_e;

  typedef enum logic [1:0] {
    PART_REG,
    PART_MEM,
    PART_HALT,
    PART_NONE
  } tracePart_e;

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    W1,
    W2
  } serState_e;

  typedef struct packed {
    logic              isReg;
    logic              isLoad;
    logic              isStore;
    logic              isHalt;
    logic [IDX_W-1:0]  regIdx;
    logic [DATA_W-1:0] regData;
    logic [DATA_W-1:0] memAddr;
    logic [DATA_W-1:0] memData;
    logic [DATA_W-1:0] instCount;
    logic [DATA_W-1:0] cycleCount;
  } traceRec_t;

  function automatic logic [DATA_W-1:0] headerWord(input traceType_e t,
                                                   input logic [IDX_W-1:0] idx);
    return {t, {(DATA_W-TYPE_W-IDX_W){1'b0}}, idx};
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// Record FIFO with wrap-around pointers; exposes the head and the entry behind it.
module trace_fifo
  import trace_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      wrEn,
  input  traceRec_t wrData,
  input  logic      rdEn,
  output traceRec_t rdData,
  output traceRec_t nextData,
  output logic      empty,
  output logic      full,
  output logic      hasNext
);

  localparam int AW = $clog2(DEPTH);

  traceRec_t     mem [DEPTH];
  logic [AW:0]   wrPtr;
  logic [AW:0]   rdPtr;
  logic [AW:0]   count;
  logic [AW-1:0] nextIdx;

  assign count    = wrPtr - rdPtr;
  assign empty    = (count == '0);
  assign full     = (count == (AW+1)'(DEPTH));
  assign hasNext  = (count > (AW+1)'(1));
  assign nextIdx  = rdPtr[AW-1:0] + AW'(1);
  assign rdData   = mem[rdPtr[AW-1:0]];
  assign nextData = mem[nextIdx];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
    end else begin
      if (wrEn) wrPtr <= wrPtr + (AW+1)'(1);
      if (rdEn) rdPtr <= rdPtr + (AW+1)'(1);
    end
  end

  // When full, a write lands on the slot being popped in the same cycle.
  always_ff @(posedge clk) begin
    if (wrEn) mem[wrPtr[AW-1:0]] <= wrData;
  end

endmodule

// File: rtl/trace_emitter.sv
// Captures retiring events into records and streams them as 16-bit trace words.
module trace_emitter
  import trace_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              reg_wr_en,
  input  logic [IDX_W-1:0]  reg_wr_idx,
  input  logic [DATA_W-1:0] reg_wr_data,
  input  logic              mem_rd_en,
  input  logic              mem_wr_en,
  input  logic [DATA_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              halt,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              overflow,
  output logic              done
);

  function automatic logic [DATA_W-1:0] satInc(input logic [DATA_W-1:0] v);
    return (&v) ? v : v + DATA_W'(1);
  endfunction

  function automatic tracePart_e nextPart(input traceRec_t r, input tracePart_e p);
    tracePart_e n;
    n = PART_NONE;
    if (p == PART_NONE && r.isReg) n = PART_REG;
    else if ((p == PART_NONE || p == PART_REG) && (r.isLoad || r.isStore)) n = PART_MEM;
    else if (p != PART_HALT && r.isHalt) n = PART_HALT;
    return n;
  endfunction

  function automatic logic [DATA_W-1:0] wordOf(input traceRec_t r, input tracePart_e p,
                                               input serState_e s);
    logic [DATA_W-1:0] w;
    w = '0;
    case (p)
      PART_REG:  w = (s == HDR) ? headerWord(TYPE_REG, r.regIdx) : r.regData;
      PART_MEM: begin
        if (s == HDR) w = r.isStore ? headerWord(TYPE_STORE, '0) : headerWord(TYPE_LOAD, '0);
        else if (s == W1) w = r.memAddr;
        else w = r.memData;
      end
      PART_HALT: begin
        if (s == HDR) w = headerWord(TYPE_HALT, '0);
        else if (s == W1) w = r.instCount;
        else w = r.cycleCount;
      end
      default: w = '0;
    endcase
    return w;
  endfunction

  function automatic logic lastOf(input traceRec_t r, input tracePart_e p, input serState_e s);
    logic partEnd;
    partEnd = (p == PART_REG) ? (s == W1) : (s == W2);
    return partEnd && (nextPart(r, p) == PART_NONE);
  endfunction

  logic              halted;
  logic [DATA_W-1:0] instCount;
  logic [DATA_W-1:0] cycleCount;
  logic [DATA_W-1:0] instNext;
  logic              evt;
  logic              push;
  logic              pop;
  logic              xfer;
  traceRec_t         capRec;
  traceRec_t         headRec;
  traceRec_t         nextRec;
  logic              fifoEmpty;
  logic              fifoFull;
  logic              fifoHasNext;
  serState_e         state;
  tracePart_e        part;
  serState_e         advState;
  tracePart_e        advPart;
  tracePart_e        headFirst;
  tracePart_e        nextFirst;

  // Capture: build the record for this cycle's retiring events
  assign evt      = !halted && (reg_wr_en || mem_rd_en || mem_wr_en || halt);
  assign instNext = (!halted && (reg_wr_en || mem_wr_en || halt)) ? satInc(instCount) : instCount;
  assign xfer     = out_valid && out_ready;
  assign pop      = xfer && out_last;
  assign push     = evt && (!fifoFull || pop);

  always_comb begin
    capRec            = '0;
    capRec.isReg      = reg_wr_en;
    capRec.isStore    = mem_wr_en;
    capRec.isLoad     = mem_rd_en && !mem_wr_en;
    capRec.isHalt     = halt;
    capRec.regIdx     = reg_wr_idx;
    capRec.regData    = reg_wr_data;
    capRec.memAddr    = mem_addr;
    capRec.memData    = mem_wr_en ? mem_wdata : mem_rdata;
    capRec.instCount  = instNext;
    capRec.cycleCount = cycleCount;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      halted     <= 1'b0;
      instCount  <= '0;
      cycleCount <= '0;
      overflow   <= 1'b0;
    end else if (!halted) begin
      instCount  <= instNext;
      cycleCount <= cycleCount + DATA_W'(1);
      if (halt) halted <= 1'b1;
      if (evt && fifoFull && !pop) overflow <= 1'b1;
    end
  end

  trace_fifo #(.DEPTH(DEPTH)) uFifo (
    .clk      (clk),
    .rst      (rst),
    .wrEn     (push),
    .wrData   (capRec),
    .rdEn     (pop),
    .rdData   (headRec),
    .nextData (nextRec),
    .empty    (fifoEmpty),
    .full     (fifoFull),
    .hasNext  (fifoHasNext)
  );

  // Serialize: walk REG, MEM, HALT parts of the head record word by word
  assign headFirst = nextPart(headRec, PART_NONE);
  assign nextFirst = nextPart(nextRec, PART_NONE);

  always_comb begin
    advState = state;
    advPart  = part;
    if (state == HDR) begin
      advState = W1;
    end else if (state == W1 && part != PART_REG) begin
      advState = W2;
    end else begin
      advState = HDR;
      advPart  = nextPart(headRec, part);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      part      <= PART_NONE;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!fifoEmpty) begin
            state     <= HDR;
            part      <= headFirst;
            out_valid <= 1'b1;
            out_data  <= wordOf(headRec, headFirst, HDR);
            out_last  <= 1'b0;
          end
        end
        default: begin
          if (xfer && out_last) begin
            if (part == PART_HALT) done <= 1'b1;
            if (fifoHasNext) begin
              state    <= HDR;
              part     <= nextFirst;
              out_data <= wordOf(nextRec, nextFirst, HDR);
              out_last <= 1'b0;
            end else begin
              state     <= IDLE;
              part      <= PART_NONE;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
            end
          end else if (xfer) begin
            state    <= advState;
            part     <= advPart;
            out_data <= wordOf(headRec, advPart, advState);
            out_last <= lastOf(headRec, advPart, advState);
          end
        end
      endcase
    end
  end

endmodule

// File: doc/trace_emitter.md
TRACE_EMITTER -- requirements
Module: trace_emitter

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning event FIFO entries (power of two, >=2).
REQ-002 SHALL have port clk  input  1  clock, all state on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port reg_wr_en  input  1  retiring register write this cycle.
REQ-005 SHALL have port reg_wr_idx  input  3  register written.
REQ-006 SHALL have port reg_wr_data  input  16  value written.
REQ-007 SHALL have port mem_rd_en  input  1  retiring load this cycle.
REQ-008 SHALL have port mem_wr_en  input  1  retiring store this cycle.
REQ-009 SHALL have port mem_addr  input  16  load/store address.
REQ-010 SHALL have port mem_wdata  input  16  store data.
REQ-011 SHALL have port mem_rdata  input  16  load data.
REQ-012 SHALL have port halt  input  1  halt retiring this cycle.
REQ-013 SHALL have port out_valid  output  1  out_data holds a valid trace word.
REQ-014 SHALL have port out_ready  input  1  consumer accepts word.
REQ-015 SHALL have port out_data  output  16  trace word.
REQ-016 SHALL have port out_last  output  1  final word of a record.
REQ-017 SHALL have port overflow  output  1  sticky: an event was dropped.
REQ-018 SHALL have port done  output  1  HALT record fully accepted.

Function
REQ-019 SHALL capture one event record per cycle where any of reg_wr_en, mem_rd_en, mem_wr_en, halt is 1, storing all flags and fields (memory data = mem_rdata if load else mem_wdata).
REQ-020 SHALL push the record at the rising edge ending the event cycle; out_valid earliest one cycle later.
REQ-021 SHALL serialize each record in order: REG pair, then LOAD or STORE triple, then HALT triple; absent parts skipped.
REQ-022 REG words: header {3'b001,10'b0,idx}, data.
REQ-023 LOAD words: header {3'b010,13'b0}, addr, rdata; STORE: header {3'b011,13'b0}, addr, wdata; mem_rd_en and mem_wr_en both 1 SHALL emit STORE only.
REQ-024 HALT words: header {3'b100,13'b0}, inst_count, cycle_count (values latched at capture).
REQ-025 out_last SHALL be 1 only on the final word of the entire record.
REQ-026 inst_count: 16-bit, saturating at 0xFFFF, +1 per cycle with reg_wr_en|mem_wr_en|halt, including the halt cycle.
REQ-027 cycle_count: 16-bit wrapping, +1 every cycle after reset until halt captured; HALT carries value of the halt cycle (first cycle after reset = 0).
REQ-028 Handshake: word transfers when out_valid&out_ready; out_data/out_last SHALL hold stable while out_valid&!out_ready; out_valid never drops without transfer.
REQ-029 FIFO entry SHALL free on transfer of its out_last word; push into a full FIFO SHALL succeed only when that pop occurs same cycle.
REQ-030 Event arriving with FIFO full and no same-cycle pop SHALL be dropped and set overflow until reset; counters still update.
REQ-031 After halt captured, all further inputs SHALL be ignored and counters frozen.
REQ-032 Serializer FSM states IDLE, HDR, W1, W2; IDLE->HDR on FIFO non-empty; advance only on transfer; after last word return to IDLE or HDR of next record with no bubble.
REQ-033 done SHALL assert the cycle after the HALT out_last transfer and hold until reset.

Reset
REQ-034 On rst low: out_valid=0, out_data=0, out_last=0, overflow=0, done=0, FIFO empty, counters 0, FSM IDLE, halt flag cleared; asserting mid-record discards it.

Structure
REQ-035 Package trace_pkg SHALL hold type codes (REG, LOAD, STORE, HALT), record field layout and width constants.
REQ-036 Sub-module trace_fifo (DEPTH x record, wrap-around pointers, full/empty) SHALL be instantiated once.

Verification
REQ-037 reg_wr_en, idx 5, data 0x1234, out_ready=1 -> 0x2005, 0x1234(last).
REQ-038 load addr 0x0040 rdata 0xBEEF with reg write r2 0xBEEF -> 0x2002, 0xBEEF, 0x4000, 0x0040, 0xBEEF(last).
REQ-039 out_ready=0 for 10 cycles mid-STORE -> words held stable, sequence unchanged after release.
REQ-040 out_ready=0, 5 consecutive stores, DEPTH=4 -> 4 records emitted, 5th dropped, overflow=1.
REQ-041 3 reg writes then halt at cycle 9 -> HALT words 0x8000, 0x0004, 0x0009; done next cycle; later inputs ignored.
REQ-042 rst low mid-record -> all outputs 0 next evaluation, no partial record after release.
